// File: rtl/line_memory_responder.sv
// -----------------------------------------------------------------------------
// line_memory_responder
//
// Off-chip data memory model behind the L1 data cache memory port. It answers
// line-granular requests (256-bit lines, 32-bit byte address) with a fixed,
// programmable latency and a one-cycle completion pulse. It is the only memory
// the CPU data path sees.
//
// Handshake: the initiator raises enable_i with write_i/addr_i/data_i and holds
// enable_i high until it samples ack_o. The responder samples a request only
// in IDLE, works from its latched copy afterwards (inputs ignored while busy),
// and pulses ack_o for exactly one cycle. A request is never aborted by
// dropping enable_i; only rst_i cancels it. At least one IDLE cycle separates
// consecutive acks.
//
// Parameters:
//   LATENCY    (1..255) ack_o rises in the cycle after the LATENCY-th rising
//              edge, counting the request-sampling edge as the first
//   DEPTH_LOG2 log2 of the number of lines
//
// Ports:
//   clk_i     in   1    clock, rising edge
//   rst_i     in   1    asynchronous, active-low reset
//   enable_i  in   1    request valid
//   write_i   in   1    1 = line write (write-back), 0 = line read (fill)
//   addr_i    in   32   byte address; [4:0] ignored, [5 +: DEPTH_LOG2] = line
//   data_i    in   256  write line data
//   rd_cnt_o  out  16   completed reads, saturating (LINE_MEM_STATS_EN only)
//   wr_cnt_o  out  16   completed writes, saturating (LINE_MEM_STATS_EN only)
//   ack_o     out  1    one-cycle completion pulse
//   data_o    out  256  read line data; holds until the next read completes
//
// Optional feature: define LINE_MEM_STATS_EN to add the read/write completion
// counters. Without it the counter ports and logic are absent.
//
// Reset clears the control state and outputs only; the line array keeps its
// contents and an in-flight write is dropped without being committed.
// -----------------------------------------------------------------------------
module line_memory_responder #(
  parameter int unsigned LATENCY    = 10,
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enable_i,
  input  logic         write_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
`ifdef LINE_MEM_STATS_EN
  output logic [15:0]  rd_cnt_o,
  output logic [15:0]  wr_cnt_o,
`endif
  output logic         ack_o,
  output logic [255:0] data_o
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [7:0]  LAT_M1 = 8'(LATENCY - 1);

  typedef logic [DEPTH_LOG2-1:0] idx_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  // Line storage. Deliberately not reset: contents survive rst_i.
  logic [255:0] mem [DEPTH];

  // Control state
  state_e       state_q, state_d;
  logic [7:0]   cnt_q,   cnt_d;
  idx_t         idx_q,   idx_d;
  logic         wr_q,    wr_d;
  logic [255:0] wdata_q, wdata_d;

  // Registered outputs
  logic         ack_q,   ack_d;
  logic [255:0] rdata_q, rdata_d;

  // Request fields as seen by the operation that completes this edge
  idx_t         req_idx;
  idx_t         op_idx;
  logic         op_wr;
  logic [255:0] op_data;
  logic         commit;

  // Address bits outside the line index do not select anything; upper bits
  // make addresses alias onto the same line.
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:5+DEPTH_LOG2], addr_i[4:0]};

  assign req_idx = addr_i[5 +: DEPTH_LOG2];

  // With LATENCY=1 the edge that samples the request is also the edge that
  // enters ACK, so the latched copy is not yet available: use the live inputs
  // while in IDLE and the latched copy otherwise.
  always_comb begin
    if (state_q == ST_IDLE) begin
      op_idx  = req_idx;
      op_wr   = write_i;
      op_data = data_i;
    end else begin
      op_idx  = idx_q;
      op_wr   = wr_q;
      op_data = wdata_q;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          idx_d   = req_idx;
          wr_d    = write_i;
          wdata_d = data_i;
          cnt_d   = LAT_M1;
          state_d = (LATENCY == 1) ? ST_ACK : ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ACK lasts one cycle and always returns to IDLE, so state_d==ST_ACK means
  // "this edge enters ACK". Gating with rst_i keeps the unreset array from
  // being written while reset is held (LATENCY=1 with enable_i high).
  assign commit = rst_i && (state_d == ST_ACK);

  assign ack_d   = commit;
  assign rdata_d = (commit && !op_wr) ? mem[op_idx] : rdata_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  // Write commits on the edge entering ACK, so a read sampled afterwards
  // (earliest: the IDLE cycle after this ACK) sees the new data.
  always_ff @(posedge clk_i) begin
    if (commit && op_wr) begin
      mem[op_idx] <= op_data;
    end
  end

  assign ack_o  = ack_q;
  assign data_o = rdata_q;

`ifdef LINE_MEM_STATS_EN
  logic [15:0] rd_cnt_q;
  logic [15:0] wr_cnt_q;

  // Completion counters, saturating so a long run never wraps to small values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (commit) begin
      if (op_wr) begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      end else begin
        if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      end
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
`endif

endmodule
